pixel_frame_writer: RTL and testbench
=====================================

// Module: pixel_frame_writer
// PURPOSE
// Capture end of the picture BRAM: fills the 640x480 RGB444 BRAM that the edge detector reads.
// Takes camera bytes already synchronised into the clk domain and packs two bytes into one 12-bit pixel.
// Writes the pixels in raster order at address y*WIDTH+x.
// Raises done after one full frame, which serves as the edge detector's start.
// PARAMETERS
// WIDTH   640  pixels per line; also the address stride
// HEIGHT  480  lines per frame; the frame holds WIDTH*HEIGHT pixels
// PORTS
// clk              in   1   system clock
// rst_n            in   1   synchronous reset, active low
// arm              in   1   request capture of the next complete frame; sampled in IDLE and DONE
// vsync            in   1   camera frame sync; high marks vertical blanking
// href             in   1   camera line valid
// byte_valid       in   1   one-cycle strobe; cam_byte is valid in that cycle
// cam_byte         in   8   camera data byte
// pic_we           out  1   BRAM write enable, one cycle per pixel
// pic_memory_addr  out  19  BRAM write address
// pic_wdata        out  12  {R,G,B}, 4 bits each
// busy             out  1   high in WAIT_VS_HI, WAIT_VS_LO and CAPTURE
// done             out  1   level; high in DONE until next arm or reset
// overflow         out  1   sticky per frame; more than WIDTH*HEIGHT pixels arrived
// short_frame      out  1   sticky per frame; fewer than WIDTH*HEIGHT pixels arrived
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; pixel count 0; byte phase 0.
// - FSM:
//   - IDLE: arm -> WAIT_VS_HI.
//   - WAIT_VS_HI: vsync=1 -> WAIT_VS_LO.
//     - This skips any frame already in progress.
//   - WAIT_VS_LO: vsync=0 -> CAPTURE; clear count, phase, overflow and short_frame.
//   - CAPTURE: rising edge of vsync (registered compare, prev=0, now=1) -> DONE.
//     - short_frame <= (count < WIDTH*HEIGHT).
//   - DONE: done=1 and held. arm -> WAIT_VS_HI; done clears in that same cycle.
// - arm is ignored while busy.
// - Byte packing, CAPTURE only, acting when byte_valid && href:
//   - phase 0: latch R = cam_byte[3:0]; phase <= 1.
//   - phase 1: pic_wdata <= {R, cam_byte[7:4], cam_byte[3:0]}; pic_memory_addr <= count.
//     - If count < WIDTH*HEIGHT: pic_we <= 1 and count++.
//     - Otherwise: overflow <= 1 and no write.
//     - phase <= 0.
// - href low resets phase to 0. A dangling odd byte at end of line is dropped.
// - Latency: pic_we, addr and data are registered and appear the cycle after the second byte's strobe.
// - pic_we is low in every other cycle. Addr and data hold their last value when not writing.
// - The address is a linear count, not a per-line x/y count.
//   - A line longer than WIDTH spills into the next line's addresses.
//   - Only the total is clamped.
// - Count is 19 bits and never wraps: it saturates at WIDTH*HEIGHT.
// - vsync rising with phase=1 pending: the pending byte is dropped and the FSM goes to DONE.
// - rst_n low mid-frame: immediate return to IDLE, outputs 0, no further writes.
//   - BRAM contents are left as-is.
// TESTING
// - Reset, then arm, then one full 640x480 frame of byte pairs (0x0A,0xBC) -> 307200 pic_we pulses.
//   - Addresses run 0..307199 contiguously; pic_wdata=12'hABC.
//   - done=1 after vsync rises; short_frame=0; overflow=0.
// - Arm issued while vsync=0 mid-frame -> that frame produces no writes; capture starts on the next frame.
// - Frame with 307201 pixels -> overflow=1; last write at addr 307199; no write at addr 307200.
// - Frame of 10 lines only -> 6400 writes; short_frame=1; done=1.
// - Odd byte before href falls, then next line (0x03,0x45) -> that pixel written as 12'h345.
//   - It lands at the next sequential address.
// - rst_n low for 1 cycle at pixel 1000 -> pic_we=0 from the next cycle; busy=0; done=0.
//   - Arm plus a new frame then restarts from address 0.

Source files
------------

// File: rtl/pixel_frame_writer.sv
// Camera capture into the picture BRAM: packs byte pairs into RGB444 pixels,
// writes them in raster order and flags done once a complete frame has been stored.
module pixel_frame_writer #(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arm,
    input  logic        vsync,
    input  logic        href,
    input  logic        byte_valid,
    input  logic [7:0]  cam_byte,
    output logic        pic_we,
    output logic [18:0] pic_memory_addr,
    output logic [11:0] pic_wdata,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic        short_frame
);

    localparam logic [18:0] NPIX = 19'(WIDTH * HEIGHT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_VS_HI,
        S_WAIT_VS_LO,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        vsync_q;
    logic        phase_q, phase_d;
    logic [3:0]  red_q, red_d;
    logic [18:0] count_q, count_d;
    logic        we_q, we_d;
    logic [18:0] addr_q, addr_d;
    logic [11:0] data_q, data_d;
    logic        ovf_q, ovf_d;
    logic        short_q, short_d;
    logic        vs_rise;

    assign vs_rise = vsync && !vsync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vsync_q <= 1'b0;
            phase_q <= 1'b0;
            red_q   <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            vsync_q <= vsync;
            phase_q <= phase_d;
            red_q   <= red_d;
            count_q <= count_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
            short_q <= short_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        red_d   = red_q;
        count_d = count_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        short_d = short_q;

        unique case (state_q)
            S_IDLE: begin
                if (arm) state_d = S_WAIT_VS_HI;
            end
            // Waiting for blanking first skips any frame already in flight.
            S_WAIT_VS_HI: begin
                if (vsync) state_d = S_WAIT_VS_LO;
            end
            S_WAIT_VS_LO: begin
                if (!vsync) begin
                    state_d = S_CAPTURE;
                    count_d = '0;
                    phase_d = 1'b0;
                    ovf_d   = 1'b0;
                    short_d = 1'b0;
                end
            end
            S_CAPTURE: begin
                if (vs_rise) begin
                    // A half-received pixel at frame end is discarded.
                    state_d = S_DONE;
                    phase_d = 1'b0;
                    short_d = (count_q < NPIX);
                end else if (!href) begin
                    phase_d = 1'b0;
                end else if (byte_valid) begin
                    if (!phase_q) begin
                        red_d   = cam_byte[3:0];
                        phase_d = 1'b1;
                    end else begin
                        data_d  = {red_q, cam_byte};
                        addr_d  = count_q;
                        phase_d = 1'b0;
                        if (count_q < NPIX) begin
                            we_d    = 1'b1;
                            count_d = count_q + 19'd1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                if (arm) state_d = S_WAIT_VS_HI;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pic_we          = we_q;
    assign pic_memory_addr = addr_q;
    assign pic_wdata       = data_q;
    assign busy            = (state_q == S_WAIT_VS_HI) || (state_q == S_WAIT_VS_LO) ||
                             (state_q == S_CAPTURE);
    assign done            = (state_q == S_DONE);
    assign overflow        = ovf_q;
    assign short_frame     = short_q;

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Self-checking bench for pixel_frame_writer on a reduced 16x4 frame, with a
// pixel-list reference model built from the byte stream each line sends.
module tb_pixel_frame_writer;

    localparam int W    = 16;
    localparam int H    = 4;
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arm = 1'b0;
    logic        vsync = 1'b0;
    logic        href = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  cam_byte = '0;
    logic        pic_we;
    logic [18:0] pic_memory_addr;
    logic [11:0] pic_wdata;
    logic        busy, done, overflow, short_frame;

    int checks = 0;
    int errors = 0;

    int unsigned exp_addr[$];
    logic [11:0] exp_data[$];
    int unsigned got_addr[$];
    logic [11:0] got_data[$];
    int unsigned mcount;
    bit          movf;

    pixel_frame_writer #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .vsync(vsync), .href(href),
        .byte_valid(byte_valid), .cam_byte(cam_byte), .pic_we(pic_we),
        .pic_memory_addr(pic_memory_addr), .pic_wdata(pic_wdata), .busy(busy),
        .done(done), .overflow(overflow), .short_frame(short_frame)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pic_we === 1'b1) begin
            got_addr.push_back(int'(pic_memory_addr));
            got_data.push_back(pic_wdata);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_addr.delete(); exp_data.delete();
        got_addr.delete(); got_data.delete();
        mcount = 0;
        movf   = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1; tick(); arm = 1'b0;
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1; repeat (3) tick();
        vsync = 1'b0; repeat (3) tick();
    endtask

    // mode 0: random bytes, 1: (0x0A,0xBC) pairs, 2: random with first pair (0x03,0x45)
    task automatic send_line(input int nbytes, input int mode, input bit rec);
        logic [7:0] b[$];
        logic [7:0] lo, hi;
        for (int i = 0; i < nbytes; i++) begin
            if (mode == 1) b.push_back((i % 2 == 0) ? 8'h0A : 8'hBC);
            else           b.push_back(8'($urandom));
        end
        if (mode == 2 && nbytes >= 2) begin
            b[0] = 8'h03;
            b[1] = 8'h45;
        end
        href = 1'b1; tick();
        foreach (b[i]) begin
            byte_valid = 1'b1; cam_byte = b[i]; tick();
            byte_valid = 1'b0; cam_byte = 8'($urandom);
            repeat ($urandom_range(0, 1)) tick();
        end
        href = 1'b0; tick(); tick();
        if (rec) begin
            for (int p = 0; p < nbytes / 2; p++) begin
                lo = b[2 * p];
                hi = b[2 * p + 1];
                if (mcount < NPIX) begin
                    exp_addr.push_back(mcount);
                    exp_data.push_back({lo[3:0], hi});
                    mcount++;
                end else begin
                    movf = 1'b1;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; repeat (3) tick();
        rst_n = 1'b1; tick();
        checks++; if (pic_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", pic_we); end
        checks++; if (pic_memory_addr !== '0) begin errors++; $display("FAIL reset_addr got %0d exp 0", pic_memory_addr); end
        checks++; if (pic_wdata !== '0) begin errors++; $display("FAIL reset_data got %h exp 000", pic_wdata); end
        checks++; if ({busy, done, overflow, short_frame} !== 4'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 0000", {busy, done, overflow, short_frame});
        end
    endtask

    task automatic test_full_frame();
        model_reset();
        pulse_arm();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arm_busy got %b exp 1", busy); end
        vsync_pulse();
        for (int l = 0; l < H; l++) begin
            send_line(2 * W, 1, 1'b1);
            if (l == 1) pulse_arm();
        end
        vsync_pulse();
        for (int i = 0; i < 20 && done !== 1'b1; i++) tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL full_done got %b exp 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy got %b exp 0", busy); end
        checks++; if ({overflow, short_frame} !== 2'b00) begin
            errors++; $display("FAIL full_flags got ovf=%b short=%b exp 0 0", overflow, short_frame);
        end
        checks++; if (got_addr.size() != exp_addr.size()) begin
            errors++; $display("FAIL full_nwrites got %0d exp %0d", got_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                errors++; $display("FAIL full_write[%0d] got %0d/%h exp %0d/%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_mid_frame_arm();
        model_reset();
        vsync_pulse();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_hold got %b exp 1", done); end
        send_line(2 * W, 0, 1'b0);
        send_line(2 * W, 0, 1'b0);
        pulse_arm();
        checks++; if ({done, busy} !== 2'b01) begin errors++; $display("FAIL rearm got done=%b busy=%b exp 0 1", done, busy); end
        send_line(2 * W, 0, 1'b0);
        send_line(2 * W, 0, 1'b0);
        checks++; if (got_addr.size() != 0) begin errors++; $display("FAIL skip_frame_writes got %0d exp 0", got_addr.size()); end
        vsync_pulse();
        for (int l = 0; l < H; l++) send_line(2 * W, 0, 1'b1);
        vsync_pulse();
        for (int i = 0; i < 20 && done !== 1'b1; i++) tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL mid_done got %b exp 1", done); end
        checks++; if (got_addr.size() != exp_addr.size()) begin
            errors++; $display("FAIL mid_nwrites got %0d exp %0d", got_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                errors++; $display("FAIL mid_write[%0d] got %0d/%h exp %0d/%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_overflow();
        model_reset();
        pulse_arm();
        vsync_pulse();
        for (int l = 0; l < H; l++) send_line(2 * W, 0, 1'b1);
        send_line(2, 0, 1'b1);
        vsync_pulse();
        for (int i = 0; i < 20 && done !== 1'b1; i++) tick();
        checks++; if (overflow !== movf) begin errors++; $display("FAIL ovf_flag got %b exp %b", overflow, movf); end
        checks++; if (short_frame !== 1'b0) begin errors++; $display("FAIL ovf_short got %b exp 0", short_frame); end
        checks++; if (int'(pic_memory_addr) != NPIX) begin errors++; $display("FAIL ovf_addr_hold got %0d exp %0d", pic_memory_addr, NPIX); end
        checks++; if (got_addr.size() != exp_addr.size()) begin
            errors++; $display("FAIL ovf_nwrites got %0d exp %0d", got_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                errors++; $display("FAIL ovf_write[%0d] got %0d/%h exp %0d/%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
        if (got_addr.size() > 0) begin
            checks++; if (got_addr[$] != NPIX - 1) begin errors++; $display("FAIL ovf_last_addr got %0d exp %0d", got_addr[$], NPIX - 1); end
        end
    endtask

    task automatic test_short_frame();
        model_reset();
        pulse_arm();
        vsync_pulse();
        send_line(2 * W, 0, 1'b1);
        send_line(2 * W, 0, 1'b1);
        // single byte pending when vsync rises with href still high
        href = 1'b1; tick();
        byte_valid = 1'b1; cam_byte = 8'h5A; tick();
        byte_valid = 1'b0; vsync = 1'b1; repeat (3) tick();
        href = 1'b0; vsync = 1'b0; repeat (3) tick();
        for (int i = 0; i < 20 && done !== 1'b1; i++) tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL short_done got %b exp 1", done); end
        checks++; if (short_frame !== 1'b1) begin errors++; $display("FAIL short_flag got %b exp 1", short_frame); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL short_ovf got %b exp 0", overflow); end
        checks++; if (got_addr.size() != exp_addr.size()) begin
            errors++; $display("FAIL short_nwrites got %0d exp %0d", got_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                errors++; $display("FAIL short_write[%0d] got %0d/%h exp %0d/%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_odd_byte();
        model_reset();
        pulse_arm();
        vsync_pulse();
        send_line(11, 0, 1'b1);
        send_line(2 * W, 2, 1'b1);
        vsync_pulse();
        for (int i = 0; i < 20 && done !== 1'b1; i++) tick();
        checks++; if (got_addr.size() <= 5) begin
            errors++; $display("FAIL odd_nwrites got %0d exp >5", got_addr.size());
        end else if (got_addr[5] !== 5 || got_data[5] !== 12'h345) begin
            errors++; $display("FAIL odd_pixel got %0d/%h exp 5/345", got_addr[5], got_data[5]);
        end
        checks++; if (got_addr.size() != exp_addr.size()) begin
            errors++; $display("FAIL odd_nwrites_model got %0d exp %0d", got_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                errors++; $display("FAIL odd_write[%0d] got %0d/%h exp %0d/%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        model_reset();
        pulse_arm();
        vsync_pulse();
        send_line(2 * W, 0, 1'b1);
        send_line(20, 0, 1'b1);
        rst_n = 1'b0; tick();
        rst_n = 1'b1;
        checks++; if ({pic_we, busy, done} !== 3'b000) begin
            errors++; $display("FAIL rst_mid_outputs got we=%b busy=%b done=%b exp 0 0 0", pic_we, busy, done);
        end
        checks++; if (pic_memory_addr !== '0) begin errors++; $display("FAIL rst_mid_addr got %0d exp 0", pic_memory_addr); end
        n = got_addr.size();
        checks++; if (n != exp_addr.size()) begin errors++; $display("FAIL rst_mid_prewrites got %0d exp %0d", n, exp_addr.size()); end
        send_line(2 * W, 0, 1'b0);
        vsync_pulse();
        checks++; if (got_addr.size() != n || done !== 1'b0) begin
            errors++; $display("FAIL rst_mid_idle got writes=%0d done=%b exp %0d 0", got_addr.size(), done, n);
        end
        model_reset();
        pulse_arm();
        vsync_pulse();
        for (int l = 0; l < H; l++) send_line(2 * W, 0, 1'b1);
        vsync_pulse();
        for (int i = 0; i < 20 && done !== 1'b1; i++) tick();
        checks++; if (got_addr.size() == 0 || got_addr[0] !== 0) begin
            errors++; $display("FAIL restart_addr0 got n=%0d first=%0d exp first 0", got_addr.size(), (got_addr.size() > 0) ? got_addr[0] : -1);
        end
        checks++; if (got_addr.size() != exp_addr.size()) begin
            errors++; $display("FAIL restart_nwrites got %0d exp %0d", got_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                errors++; $display("FAIL restart_write[%0d] got %0d/%h exp %0d/%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_mid_frame_arm();
        test_overflow();
        test_short_frame();
        test_odd_byte();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
